fp_add_arbiter: RTL and testbench
=================================

Name: fp_add_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one multi-cycle adder_fp unit among NREQ requesters.
- Accepts level requests carrying op/A/B and drives the adder's start/op/A/B.
- Tracks the adder's busy/ready handshake and returns Y to the winning requester with a one-cycle done pulse.
- Sits between the requesting datapath blocks and the single adder_fp instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 64, watchdog limit in cycles; used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req  input  NREQ  level request per requester.
- req_op  input  NREQ  per-requester op (0 = add, 1 = subtract).
- req_a  input  32*NREQ  IEEE-754 single operand A; requester i occupies bits [32i+31:32i].
- req_b  input  32*NREQ  operand B, same packing as req_a.
- ack  output  NREQ  one-cycle pulse: request accepted, operands captured.
- done  output  NREQ  one-cycle pulse: result valid for that requester.
- result  output  32  last delivered result; holds its value until the next done.
- fpu_start  output  1  adder start.
- fpu_op  output  1  adder op.
- fpu_a  output  32  adder A.
- fpu_b  output  32  adder B.
- fpu_ready  input  1  adder result valid.
- fpu_busy  input  1  adder operation in progress.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, rr_ptr=0.
  - ack, done, fpu_start, fpu_op = 0; fpu_a, fpu_b, result = 0.
  - Any in-flight adder operation is abandoned. Its result is never delivered.
- State machine: IDLE -> ISSUE -> WAIT_BUSY -> WAIT_READY -> DONE -> IDLE. All outputs are registered.
- IDLE:
  - If any req bit is set and fpu_busy=0, select the winner w: the first set bit scanning from rr_ptr upward, wrapping modulo NREQ.
  - At the edge: load fpu_op/fpu_a/fpu_b from w's fields, set ack[w]=1, fpu_start=1, latch w, go to ISSUE.
  - If fpu_busy=1 (adder still busy after reset), stay in IDLE. This is the only reset-recovery rule.
- ISSUE: fpu_start is high for exactly this one cycle; ack[w] is high this cycle only. Next state is WAIT_BUSY.
- WAIT_BUSY:
  - fpu_start=0. Exit when fpu_busy=1, going to WAIT_READY.
  - If fpu_ready=1 and fpu_busy=0 in this state (fast completion), go directly to DONE, capturing Y.
- WAIT_READY: exit when fpu_ready=1 and fpu_busy=0. At that edge result<=Y, done[w]<=1, rr_ptr<=(w+1) mod NREQ, go to DONE.
- DONE: done[w] is high for this cycle only; fpu_start is guaranteed low. Next state is IDLE. This gives at least one start-low gap between operations.
- Requester contract:
  - Hold req and operands stable until ack.
  - Drop req in the cycle after ack, or it is treated as a new request at the next IDLE.
  - req is sampled only in IDLE. Dropping req before arbitration withdraws the request cleanly.
- Simultaneous requests: exactly one grant per operation. Round-robin guarantees each requester is served within NREQ operations.
- fpu_a/fpu_b/fpu_op hold their values from ISSUE through DONE. req changes during an operation have no effect.
- Minimum latency from ack to done is 2 cycles plus the adder latency.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - Adds output port err (1 bit, reset 0) and a cycle counter cleared on entry to WAIT_BUSY.
  - If the counter reaches TIMEOUT while in WAIT_BUSY or WAIT_READY: result<=32'h7FC00000 (qNaN), done[w] and err pulse together for one cycle, rr_ptr advances, state goes to DONE.
- Not defined: no err port and no counter; the FSM waits indefinitely.

Test Plan:
- Single op, add: req[0], A=0x40C00000, B=0x40200000, op=0 -> ack[0] one pulse, fpu_start one pulse, then done[0] with result=0x41080000 (8.5).
- Single op, subtract: same operands with op=1 on req[2] -> done[2] with result=0x40600000 (3.5); done/ack never asserted for other requesters.
- Round-robin: req=4'b1111 held (each drops after its ack, then re-raises) -> grant order 0,1,2,3,0. Then req=4'b1001 raised right after requester 1 is served -> 3 granted before 0.
- Reset mid-op: rst_n=0 for one cycle while in WAIT_READY -> all outputs 0 next cycle, no done. New req is not issued until fpu_busy=0, then completes normally.
- Back-to-back: req[1] held continuously -> fpu_start is low for at least 2 cycles between successive pulses, and each operation produces exactly one done[1].
- ARB_TIMEOUT_EN with TIMEOUT=8: adder model holds fpu_busy=1 forever -> 8 cycles after entry to WAIT_BUSY, done[w]=1, err=1, result=0x7FC00000.

Source files
------------

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin sequencer sharing one multi-cycle FP adder
// among NREQ requesters. The winner's op/A/B are registered onto the adder
// port. The adder's Y is returned with a one-cycle done pulse.
// Optional watchdog: define ARB_TIMEOUT_EN to add the err output and a
// TIMEOUT-cycle limit on the adder handshake (qNaN result on expiry).
module fp_add_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_op,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [32*NREQ-1:0] req_b,
  output logic [NREQ-1:0]    ack,
  output logic [NREQ-1:0]    done,
  output logic [31:0]        result,
`ifdef ARB_TIMEOUT_EN
  output logic               err,
`endif
  output logic               fpu_start,
  output logic               fpu_op,
  output logic [31:0]        fpu_a,
  output logic [31:0]        fpu_b,
  input  logic [31:0]        fpu_y,
  input  logic               fpu_ready,
  input  logic               fpu_busy
);

  localparam int IDXW = $clog2(NREQ);
  localparam int PW   = IDXW + 1;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ISSUE      = 3'd1,
    S_WAIT_BUSY  = 3'd2,
    S_WAIT_READY = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  state_t            state_q;
  logic [IDXW-1:0]   rr_ptr_q;
  logic [IDXW-1:0]   win_q;
  logic [NREQ-1:0]   ack_q;
  logic [NREQ-1:0]   done_q;
  logic [31:0]       result_q;
  logic              start_q;
  logic              op_q;
  logic [31:0]       a_q;
  logic [31:0]       b_q;

  logic [PW-1:0]     pick_s;
  logic              pick_valid_s;
  logic [IDXW-1:0]   pick_idx_s;
  logic [IDXW-1:0]   next_ptr_s;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]     cnt_q;
  logic              err_q;
`endif

  // First set request bit at or above ptr, wrapping; MSB of result = found.
  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [IDXW-1:0] ptr);
    logic [PW-1:0] res;
    logic [PW-1:0] pos;
    res = '0;
    // Scan downward so the last hit kept is the nearest one to ptr.
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + PW'(k);
      if (pos >= PW'(NREQ)) begin
        pos = pos - PW'(NREQ);
      end else begin
        pos = pos;
      end
      if (r[pos[IDXW-1:0]]) begin
        res = {1'b1, pos[IDXW-1:0]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Round-robin winner among the currently raised requests.
  always_comb begin
    pick_s       = rr_pick(req, rr_ptr_q);
    pick_valid_s = pick_s[IDXW];
    pick_idx_s   = pick_s[IDXW-1:0];
  end

  // Pointer value after serving win_q: the requester just above it.
  always_comb begin
    if (win_q == IDXW'(NREQ - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = win_q + IDXW'(1);
    end
  end

  // Sequencer FSM with all outputs registered; pulses default low each cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      win_q    <= '0;
      ack_q    <= '0;
      done_q   <= '0;
      result_q <= 32'h0000_0000;
      start_q  <= 1'b0;
      op_q     <= 1'b0;
      a_q      <= 32'h0000_0000;
      b_q      <= 32'h0000_0000;
`ifdef ARB_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      ack_q   <= '0;
      done_q  <= '0;
      start_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          // A busy adder here is a leftover from before reset: wait it out.
          if (pick_valid_s && !fpu_busy) begin
            win_q             <= pick_idx_s;
            ack_q[pick_idx_s] <= 1'b1;
            start_q           <= 1'b1;
            op_q              <= req_op[pick_idx_s];
            a_q               <= req_a[{pick_idx_s, 5'd0} +: 32];
            b_q               <= req_b[{pick_idx_s, 5'd0} +: 32];
            state_q           <= S_ISSUE;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT_BUSY;
`ifdef ARB_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        S_WAIT_BUSY, S_WAIT_READY: begin
          // Completion may also arrive in WAIT_BUSY if the adder never showed busy.
          if (fpu_ready && !fpu_busy) begin
            result_q      <= fpu_y;
            done_q[win_q] <= 1'b1;
            rr_ptr_q      <= next_ptr_s;
            state_q       <= S_DONE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (cnt_q == CW'(TIMEOUT - 1)) begin
            result_q      <= 32'h7FC0_0000;
            done_q[win_q] <= 1'b1;
            err_q         <= 1'b1;
            rr_ptr_q      <= next_ptr_s;
            state_q       <= S_DONE;
          end
`endif
          else if (fpu_busy) begin
            state_q <= S_WAIT_READY;
          end else begin
            state_q <= state_q;
          end
`ifdef ARB_TIMEOUT_EN
          cnt_q <= cnt_q + CW'(1);
`endif
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ack       = ack_q;
  assign done      = done_q;
  assign result    = result_q;
  assign fpu_start = start_q;
  assign fpu_op    = op_q;
  assign fpu_a     = a_q;
  assign fpu_b     = b_q;
`ifdef ARB_TIMEOUT_EN
  assign err       = err_q;
`endif

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Testbench for fp_add_arbiter: behavioural adder stand-in plus a
// round-robin reference model (pointer + modulo scan) and per-scenario tasks.
module tb_fp_add_arbiter;

  localparam int NREQ = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_v = '0;
  logic [NREQ-1:0]     op_v = '0;
  logic [31:0]         a_arr [NREQ];
  logic [31:0]         b_arr [NREQ];
  logic [32*NREQ-1:0]  req_a_s;
  logic [32*NREQ-1:0]  req_b_s;
  logic [NREQ-1:0]     ack;
  logic [NREQ-1:0]     done;
  logic [31:0]         result;
  logic                fpu_start;
  logic                fpu_op;
  logic [31:0]         fpu_a;
  logic [31:0]         fpu_b;
  logic [31:0]         fpu_y = 32'h0;
  logic                fpu_ready = 1'b0;
  logic                fpu_busy = 1'b0;
`ifdef ARB_TIMEOUT_EN
  logic                err;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;
  int exp_ptr = 0;
  logic [NREQ-1:0] persist = '0;
  int cyc = 0;
  int last_start_cyc = 0;

  // Adder stand-in configuration
  int m_lat = 3;
  bit m_fast = 1'b0;
  bit m_hang = 1'b0;
  int m_cnt = 0;
  logic [31:0] m_y = 32'h0;

  fp_add_arbiter #(.NREQ(NREQ), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req_v), .req_op(op_v),
    .req_a(req_a_s), .req_b(req_b_s), .ack(ack), .done(done), .result(result),
`ifdef ARB_TIMEOUT_EN
    .err(err),
`endif
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_y(fpu_y), .fpu_ready(fpu_ready), .fpu_busy(fpu_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    req_a_s = '0;
    req_b_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a_s[32*i +: 32] = a_arr[i];
      req_b_s[32*i +: 32] = b_arr[i];
    end
  end

  // Stand-in adder result: exact IEEE words for the reference vectors,
  // integer add/sub otherwise (the arbiter only transports the word).
  function automatic logic [31:0] fake_add(input logic op, input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40C0_0000 && b == 32'h4020_0000) return op ? 32'h4060_0000 : 32'h4108_0000;
    return op ? (a - b) : (a + b);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int w);
    logic [NREQ-1:0] r;
    r = '0;
    r[w] = 1'b1;
    return r;
  endfunction

  // Reference arbitration rule: first raised request from ptr, wrapping.
  function automatic int pick(input logic [NREQ-1:0] m, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (ptr + k) % NREQ;
      if (m[idx]) return idx;
    end
    return 0;
  endfunction

  // Multi-cycle adder model: busy for m_lat cycles, then one-cycle ready.
  always @(posedge clk) begin
    fpu_ready <= 1'b0;
    if (m_cnt > 0) begin
      if (m_cnt == 1) begin
        fpu_busy  <= 1'b0;
        fpu_ready <= 1'b1;
        fpu_y     <= m_y;
      end
      m_cnt <= m_cnt - 1;
    end else if (fpu_start === 1'b1 && fpu_busy === 1'b0) begin
      if (m_hang) begin
        fpu_busy <= 1'b1;
      end else if (m_fast) begin
        fpu_ready <= 1'b1;
        fpu_y     <= fake_add(fpu_op, fpu_a, fpu_b);
      end else begin
        fpu_busy <= 1'b1;
        m_y      <= fake_add(fpu_op, fpu_a, fpu_b);
        m_cnt    <= m_lat;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for a grant to w, checks issue, then waits for and checks completion.
  task automatic serve_one(input int w, input bit hold, input int exp_lat);
    int n;
    int stray;
    logic [31:0] exp_y;
    logic [NREQ-1:0] oh;
    oh = onehot(w);
    n = 0;
    stray = 0;
    while (ack === '0 && n < 100) begin
      if (done !== '0) stray++;
      step();
      n++;
    end
    total_cnt++;
    if (ack !== oh) $display("FAIL grant: ack=%b expected %b", ack, oh);
    else pass_cnt++;
    total_cnt++;
    if (fpu_start !== 1'b1 || fpu_op !== op_v[w] || fpu_a !== a_arr[w] || fpu_b !== b_arr[w])
      $display("FAIL issue: start=%b op=%b a=%h b=%h expected 1 %b %h %h",
               fpu_start, fpu_op, fpu_a, fpu_b, op_v[w], a_arr[w], b_arr[w]);
    else pass_cnt++;
    exp_y = fake_add(op_v[w], a_arr[w], b_arr[w]);
    last_start_cyc = cyc;
    if (!hold) req_v[w] = 1'b0;
    step();
    n = 1;
    total_cnt++;
    if (fpu_start !== 1'b0 || ack !== '0)
      $display("FAIL pulse_width: start=%b ack=%b expected 0 0", fpu_start, ack);
    else pass_cnt++;
    if (persist[w] && !hold) req_v[w] = 1'b1;
    while (done === '0 && n < 200) begin
      if (ack !== '0) stray++;
      step();
      n++;
    end
    total_cnt++;
    if (done !== oh || result !== exp_y)
      $display("FAIL done: done=%b result=%h expected %b %h", done, result, oh, exp_y);
    else pass_cnt++;
    total_cnt++;
    if (stray !== 0) $display("FAIL stray_pulse: count=%0d expected 0", stray);
    else pass_cnt++;
    if (exp_lat > 0) begin
      total_cnt++;
      if (n !== exp_lat) $display("FAIL latency: %0d cycles expected %0d", n, exp_lat);
      else pass_cnt++;
    end
    exp_ptr = (w + 1) % NREQ;
    step();
    total_cnt++;
    if (done !== '0) $display("FAIL done_width: done=%b expected 0", done);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_v = '0;
    step();
    step();
    total_cnt++;
    if (ack !== '0 || done !== '0) $display("FAIL reset_pulses: ack=%b done=%b expected 0 0", ack, done);
    else pass_cnt++;
    total_cnt++;
    if (fpu_start !== 1'b0 || fpu_op !== 1'b0 || fpu_a !== 32'h0 || fpu_b !== 32'h0)
      $display("FAIL reset_fpu: start=%b op=%b a=%h b=%h expected all 0", fpu_start, fpu_op, fpu_a, fpu_b);
    else pass_cnt++;
    total_cnt++;
    if (result !== 32'h0) $display("FAIL reset_result: %h expected 0", result);
    else pass_cnt++;
`ifdef ARB_TIMEOUT_EN
    total_cnt++;
    if (err !== 1'b0) $display("FAIL reset_err: %b expected 0", err);
    else pass_cnt++;
`endif
    rst_n = 1'b1;
    exp_ptr = 0;
  endtask

  task automatic test_single_add();
    m_fast = 1'b0;
    m_lat = 3;
    a_arr[0] = 32'h40C0_0000;
    b_arr[0] = 32'h4020_0000;
    op_v[0] = 1'b0;
    req_v[0] = 1'b1;
    serve_one(0, 1'b0, 5);
    total_cnt++;
    if (result !== 32'h4108_0000) $display("FAIL add_result: %h expected 41080000", result);
    else pass_cnt++;
  endtask

  task automatic test_single_sub();
    a_arr[2] = 32'h40C0_0000;
    b_arr[2] = 32'h4020_0000;
    op_v[2] = 1'b1;
    req_v[2] = 1'b1;
    serve_one(2, 1'b0, 5);
    total_cnt++;
    if (result !== 32'h4060_0000) $display("FAIL sub_result: %h expected 40600000", result);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int order [6];
    order = '{0, 1, 2, 3, 0, 1};
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_ptr = 0;
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = $urandom;
      b_arr[i] = $urandom;
      op_v[i] = 1'($urandom_range(0, 1));
    end
    persist = '1;
    req_v = '1;
    for (int i = 0; i < 6; i++) serve_one(order[i], 1'b0, m_lat + 2);
    persist = '0;
    req_v = 4'b1001;
    serve_one(3, 1'b0, m_lat + 2);
    serve_one(0, 1'b0, m_lat + 2);
  endtask

  task automatic test_random();
    logic [NREQ-1:0] outstanding;
    int w;
    for (int it = 0; it < 12; it++) begin
      m_fast = ($urandom_range(0, 3) == 0);
      m_lat = $urandom_range(1, 6);
      for (int i = 0; i < NREQ; i++) begin
        a_arr[i] = $urandom;
        b_arr[i] = $urandom;
        op_v[i] = 1'($urandom_range(0, 1));
      end
      outstanding = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      req_v = outstanding;
      while (outstanding !== '0) begin
        w = pick(outstanding, exp_ptr);
        serve_one(w, 1'b0, m_fast ? 2 : m_lat + 2);
        outstanding[w] = 1'b0;
      end
    end
    m_fast = 1'b0;
    m_lat = 3;
  endtask

  task automatic test_back_to_back();
    int prev;
    int gap;
    int stray;
    m_lat = 2;
    a_arr[1] = $urandom;
    b_arr[1] = $urandom;
    op_v[1] = 1'b0;
    req_v = 4'b0010;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      serve_one(1, 1'b1, 4);
      if (k > 0) begin
        gap = last_start_cyc - prev - 1;
        total_cnt++;
        if (gap < 2) $display("FAIL start_gap: %0d low cycles expected >= 2", gap);
        else pass_cnt++;
      end
      prev = last_start_cyc;
    end
    req_v = '0;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ack !== '0 || done !== '0) stray++;
    end
    total_cnt++;
    if (stray !== 0) $display("FAIL withdraw: %0d stray pulses expected 0", stray);
    else pass_cnt++;
    m_lat = 3;
  endtask

  task automatic test_reset_mid_op();
    int n;
    int stray;
    m_lat = 10;
    a_arr[0] = $urandom;
    b_arr[0] = $urandom;
    op_v[0] = 1'b0;
    req_v = 4'b0001;
    n = 0;
    while (ack === '0 && n < 40) begin
      step();
      n++;
    end
    total_cnt++;
    if (ack !== 4'b0001) $display("FAIL midop_grant: ack=%b expected 0001", ack);
    else pass_cnt++;
    req_v = '0;
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_ptr = 0;
    m_lat = 3;
    total_cnt++;
    if (ack !== '0 || done !== '0 || fpu_start !== 1'b0 || fpu_op !== 1'b0 ||
        fpu_a !== 32'h0 || fpu_b !== 32'h0 || result !== 32'h0)
      $display("FAIL midop_reset: ack=%b done=%b start=%b a=%h b=%h result=%h expected all 0",
               ack, done, fpu_start, fpu_a, fpu_b, result);
    else pass_cnt++;
    a_arr[2] = $urandom;
    b_arr[2] = $urandom;
    op_v[2] = 1'b1;
    req_v = 4'b0100;
    n = 0;
    stray = 0;
    while (fpu_busy === 1'b1 && n < 40) begin
      if (ack !== '0 || done !== '0) stray++;
      step();
      n++;
    end
    total_cnt++;
    if (stray !== 0 || n == 0)
      $display("FAIL busy_hold: stray=%0d busy_cycles=%0d expected 0 and >0", stray, n);
    else pass_cnt++;
    serve_one(2, 1'b0, 5);
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    int early;
    m_hang = 1'b1;
    a_arr[3] = $urandom;
    b_arr[3] = $urandom;
    op_v[3] = 1'b0;
    req_v = 4'b1000;
    n = 0;
    while (ack === '0 && n < 40) begin
      step();
      n++;
    end
    total_cnt++;
    if (ack !== 4'b1000) $display("FAIL to_grant: ack=%b expected 1000", ack);
    else pass_cnt++;
    req_v = '0;
    early = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (done !== '0 || err !== 1'b0) early++;
    end
    step();
    total_cnt++;
    if (early !== 0) $display("FAIL to_early: %0d premature cycles expected 0", early);
    else pass_cnt++;
    total_cnt++;
    if (done !== 4'b1000 || err !== 1'b1 || result !== 32'h7FC0_0000)
      $display("FAIL to_fire: done=%b err=%b result=%h expected 1000 1 7fc00000", done, err, result);
    else pass_cnt++;
    step();
    total_cnt++;
    if (done !== '0 || err !== 1'b0) $display("FAIL to_pulse: done=%b err=%b expected 0 0", done, err);
    else pass_cnt++;
  endtask
`endif

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = 32'h0;
      b_arr[i] = 32'h0;
    end
    test_reset();
    test_single_add();
    test_single_sub();
    test_round_robin();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
